// File: rtl/servo_pkg.sv
// Shared constants and state encoding for the servo PWM generator.
package servo_pkg;

    localparam int unsigned DUTY_W         = 24;
    localparam int unsigned SERVO_PERIOD   = 1_000_000;
    localparam int unsigned SERVO_DUTY_MIN = 20_000;
    localparam int unsigned SERVO_DUTY_MAX = 120_000;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;

endpackage

// File: rtl/pwm_period_counter.sv
// Free-running period counter: counts 0..PERIOD-1 while run is high, holds 0 otherwise.
module pwm_period_counter
    import servo_pkg::*;
#(
    parameter int unsigned PERIOD = SERVO_PERIOD,
    parameter int unsigned CW     = $clog2(PERIOD)
) (
    input  logic          clk_in,
    input  logic          rst,
    input  logic          run,
    output logic [CW-1:0] cnt,
    output logic          last
);

    assign last = (cnt == CW'(PERIOD - 1));

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!run || last) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/servo_pwm.sv
// Servo PWM generator: per-period latched, clamped pulse width with drain-on-disable.
module servo_pwm
    import servo_pkg::*;
#(
    parameter int unsigned PERIOD   = SERVO_PERIOD,
    parameter int unsigned DUTY_MIN = SERVO_DUTY_MIN,
    parameter int unsigned DUTY_MAX = SERVO_DUTY_MAX,
    parameter int unsigned W        = DUTY_W
) (
    input  logic         clk_in,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] duty,
    output logic         pwm_out,
    output logic         period_start,
    output logic [W-1:0] duty_active,
    output logic         running
);

    localparam int unsigned CW = $clog2(PERIOD);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt_c;
    logic          last;
    logic          run_c;
    logic          load_c;
    logic          active_nxt_c;
    logic [W-1:0]  duty_clamped_c;
    logic [W-1:0]  duty_nxt_c;

    function automatic logic [W-1:0] clamp_duty(input logic [W-1:0] d);
        if (d < W'(DUTY_MIN)) begin
            return W'(DUTY_MIN);
        end else if (d > W'(DUTY_MAX)) begin
            return W'(DUTY_MAX);
        end else begin
            return d;
        end
    endfunction

    assign run_c = (state != ST_IDLE);

    pwm_period_counter #(
        .PERIOD (PERIOD),
        .CW     (CW)
    ) u_counter (
        .clk_in (clk_in),
        .rst    (rst),
        .run    (run_c),
        .cnt    (cnt),
        .last   (last)
    );

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (en) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!en) begin
                    state_nxt = last ? ST_IDLE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (en) begin
                    state_nxt = ST_RUN;
                end else if (last) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Next-cycle view of counter and width, so the registered outputs line up with cnt.
    always_comb begin
        duty_clamped_c = clamp_duty(duty);
        load_c         = ((state == ST_IDLE) && en) || ((state == ST_RUN) && last);
        duty_nxt_c     = load_c ? duty_clamped_c : duty_active;
        cnt_nxt_c      = (!run_c || last) ? '0 : cnt + CW'(1);
        active_nxt_c   = (state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            duty_active  <= W'(DUTY_MIN);
            running      <= 1'b0;
            period_start <= 1'b0;
            pwm_out      <= 1'b0;
        end else begin
            duty_active  <= duty_nxt_c;
            running      <= active_nxt_c;
            period_start <= active_nxt_c && (cnt_nxt_c == '0);
            pwm_out      <= active_nxt_c && (W'(cnt_nxt_c) < duty_nxt_c);
        end
    end

endmodule

// File: tb/tb_servo_pwm.sv
// Directed bench for servo_pwm with a short period (PERIOD=100, clamp 5..50).
module tb_servo_pwm;

    localparam int unsigned PERIOD   = 100;
    localparam int unsigned DUTY_MIN = 5;
    localparam int unsigned DUTY_MAX = 50;
    localparam int unsigned W        = 24;

    logic         clk_in;
    logic         rst;
    logic         en;
    logic [W-1:0] duty;
    logic         pwm_out;
    logic         period_start;
    logic [W-1:0] duty_active;
    logic         running;

    int tests;
    int fails;

    servo_pwm #(
        .PERIOD   (PERIOD),
        .DUTY_MIN (DUTY_MIN),
        .DUTY_MAX (DUTY_MAX),
        .W        (W)
    ) dut (
        .clk_in       (clk_in),
        .rst          (rst),
        .en           (en),
        .duty         (duty),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .duty_active  (duty_active),
        .running      (running)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Advance one cycle and check the waveform outputs for that cycle.
    task automatic check_cycle(input string tag, input logic e_pwm, input logic e_ps, input logic e_run);
        tick();
        chk({tag, ".pwm"}, 32'(pwm_out), 32'(e_pwm));
        chk({tag, ".ps"}, 32'(period_start), 32'(e_ps));
        chk({tag, ".run"}, 32'(running), 32'(e_run));
    endtask

    task automatic check_period(input string tag, input int dw);
        for (int k = 0; k < int'(PERIOD); k++) begin
            check_cycle(tag, k < dw, k == 0, 1'b1);
        end
    endtask

    task automatic check_idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            check_cycle(tag, 1'b0, 1'b0, 1'b0);
            chk({tag, ".cnt"}, 32'(dut.cnt), 32'd0);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        en    = 1'b0;
        duty  = 24'd20;

        // Reset state
        tick(); tick(); tick();
        chk("rst.pwm", 32'(pwm_out), 32'd0);
        chk("rst.ps", 32'(period_start), 32'd0);
        chk("rst.run", 32'(running), 32'd0);
        chk("rst.duty_active", 32'(duty_active), 32'd5);
        chk("rst.cnt", 32'(dut.cnt), 32'd0);
        rst = 1'b0;
        check_idle("idle0", 2);

        // Basic 20-cycle pulse, two full periods
        en = 1'b1;
        check_period("p20a", 20);
        chk("p20a.duty_active", 32'(duty_active), 32'd20);
        check_period("p20b", 20);

        // Clamp low then high; new duty presented before the latch edge
        duty = 24'd2;
        check_period("pmin", 5);
        chk("pmin.duty_active", 32'(duty_active), 32'd5);
        duty = 24'd80;
        check_period("pmax", 50);
        chk("pmax.duty_active", 32'(duty_active), 32'd50);

        // Mid-period change does not affect the current pulse
        duty = 24'd20;
        for (int k = 0; k < int'(PERIOD); k++) begin
            check_cycle("midchg", k < 20, k == 0, 1'b1);
            if (k == 10) duty = 24'd40;
        end
        // Glitch that reverts before the latch edge is never seen
        for (int k = 0; k < int'(PERIOD); k++) begin
            check_cycle("p40", k < 40, k == 0, 1'b1);
            if (k == 50) duty = 24'd45;
            if (k == 60) duty = 24'd40;
        end
        chk("p40.duty_active", 32'(duty_active), 32'd40);
        check_period("p40b", 40);

        // Drop en at cnt=7: drain the period, then IDLE
        duty = 24'd20;
        for (int k = 0; k < int'(PERIOD); k++) begin
            check_cycle("drain", k < 20, k == 0, 1'b1);
            if (k == 7) en = 1'b0;
        end
        check_idle("drain.idle", 3);
        chk("drain.duty_active", 32'(duty_active), 32'd20);

        // en low at 30, high at 60: no restart, strobe stays 100 cycles apart
        en = 1'b1;
        for (int k = 0; k < int'(PERIOD); k++) begin
            check_cycle("toggle", k < 20, k == 0, 1'b1);
            if (k == 30) en = 1'b0;
            if (k == 60) en = 1'b1;
        end
        check_period("toggle.next", 20);
        // en low exactly at the last cycle goes straight to IDLE
        en = 1'b0;
        check_idle("lastdrop.idle", 2);

        // Reset mid-pulse truncates immediately
        en   = 1'b1;
        duty = 24'd20;
        for (int k = 0; k <= 10; k++) begin
            check_cycle("prerst", k < 20, k == 0, 1'b1);
        end
        rst = 1'b1;
        #1;
        chk("arst.pwm", 32'(pwm_out), 32'd0);
        chk("arst.ps", 32'(period_start), 32'd0);
        chk("arst.run", 32'(running), 32'd0);
        chk("arst.duty_active", 32'(duty_active), 32'd5);
        en = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check_idle("postrst", 2);
        en = 1'b1;
        check_period("restart", 20);
        chk("restart.duty_active", 32'(duty_active), 32'd20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
